// File: rtl/lwe_pkg.sv
// Shared types and decode-constant helpers for the streaming LWE decryptor.
// Optional rounding decode is selected by LWE_DECRYPT_ROUND_EN (see lwe_decode).
package lwe_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DECODE,
        OUT
    } lwe_state_t;

    // Number of low accumulator bits dropped by the MSB-encoded decode.
    function automatic int decodeShift(input int cw, input int pw);
        return cw - pw;
    endfunction

    // Half of one plaintext step, added before truncation to round to nearest.
    function automatic int roundBias(input int cw, input int pw);
        return 1 << (cw - pw - 1);
    endfunction

endpackage

// File: rtl/lwe_decode.sv
// Combinational decode of the mod-q accumulator into a plaintext word.
// LWE_DECRYPT_ROUND_EN selects round-to-nearest MSB decode; default is legacy low-bit decode.
module lwe_decode
    import lwe_pkg::*;
#(
    parameter int CW = 10,
    parameter int PW = 6
) (
    input  logic [CW-1:0] acc_i,
    output logic [PW-1:0] result_o
);

`ifdef LWE_DECRYPT_ROUND_EN
    localparam int            SHIFT = decodeShift(CW, PW);
    localparam logic [CW-1:0] BIAS  = CW'(roundBias(CW, PW));

    logic [CW-1:0] biased;
    logic          unusedLowBits;

    // The add wraps mod q, so values just below q round back to plaintext 0.
    assign biased        = acc_i + BIAS;
    assign result_o      = biased[CW-1:SHIFT];
    assign unusedLowBits = ^biased[SHIFT-1:0];
`else
    logic unusedHighBits;

    assign result_o       = acc_i[PW-1:0];
    assign unusedHighBits = ^acc_i[CW-1:PW];
`endif

endmodule

// File: rtl/lwe_decrypt_stream.sv
// Streaming LWE decryptor: header beat (b) then DIMENSION (a_i,s_i) MAC beats, one decoded result.
// Decode style is chosen inside lwe_decode by the LWE_DECRYPT_ROUND_EN macro.
module lwe_decrypt_stream
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_WIDTH  = 6,
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int DIMENSION        = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_first,
    input  logic [CIPHERTEXT_WIDTH-1:0] ct_a,
    input  logic [CIPHERTEXT_WIDTH-1:0] sk,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PLAINTEXT_WIDTH-1:0]  result,
    output logic                        frame_err
);

    localparam int CW        = CIPHERTEXT_WIDTH;
    localparam int PW        = PLAINTEXT_WIDTH;
    localparam int CNT_WIDTH = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DIMENSION - 1);

    lwe_state_t           state_q;
    logic [CW-1:0]        acc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [PW-1:0]        result_q;
    logic                 out_valid_q;
    logic                 frame_err_q;

    logic [2*CW-1:0]      product_d;
    logic [CW-1:0]        macSum_d;
    logic [PW-1:0]        decoded_d;
    logic                 unusedProductHigh;

    // Only the low CW bits of the full product matter since everything is mod q.
    assign product_d         = {{CW{1'b0}}, ct_a} * {{CW{1'b0}}, sk};
    assign macSum_d          = acc_q + product_d[CW-1:0];
    assign unusedProductHigh = ^product_d[2*CW-1:CW];

    lwe_decode #(
        .CW (CW),
        .PW (PW)
    ) u_decode (
        .acc_i    (acc_q),
        .result_o (decoded_d)
    );

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign frame_err = frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (in_first) begin
                            acc_q   <= ct_a;
                            cnt_q   <= '0;
                            state_q <= ACCUM;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        // A new header mid-frame abandons the partial sum and restarts.
                        if (in_first) begin
                            acc_q       <= ct_a;
                            cnt_q       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            acc_q <= macSum_d;
                            if (cnt_q == LAST_CNT) begin
                                cnt_q   <= '0;
                                state_q <= DECODE;
                            end else begin
                                cnt_q <= cnt_q + CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                DECODE: begin
                    result_q    <= decoded_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lwe_decrypt_stream.sv
// Self-checking bench for lwe_decrypt_stream (CW=10, PW=6, D=4) with an abstract frame model.
// Expected decode follows LWE_DECRYPT_ROUND_EN when the bench is built with it.
module tb_lwe_decrypt_stream;

    localparam int CW   = 10;
    localparam int PW   = 6;
    localparam int D    = 4;
    localparam int Q    = 1 << CW;
    localparam int P    = 1 << PW;
    localparam int STEP = Q / P;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic [CW-1:0] ct_a;
    logic [CW-1:0] sk;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] result;
    logic          frame_err;

    int  compared   = 0;
    int  mismatched = 0;
    bit  randomReady = 0;

    // Abstract model: phase 0 = taking beats, 1 = decoding, 2 = presenting a result.
    int  mPhase;
    bit  mHaveHdr;
    int  mSum;
    int  mCount;
    int  mPending;
    int  mLastResult;
    bit  mFerr;

    lwe_decrypt_stream #(
        .PLAINTEXT_WIDTH  (PW),
        .CIPHERTEXT_WIDTH (CW),
        .DIMENSION        (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .ct_a      (ct_a),
        .sk        (sk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int decodeModel(input int acc);
`ifdef LWE_DECRYPT_ROUND_EN
        return ((acc + STEP / 2) % Q) / STEP;
`else
        return acc % P;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update on each accepted edge, driven only by bench-side inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase      = 0;
            mHaveHdr    = 0;
            mSum        = 0;
            mCount      = 0;
            mPending    = 0;
            mLastResult = 0;
            mFerr       = 0;
        end else begin
            mFerr = 0;
            if (mPhase == 0) begin
                if (in_valid) begin
                    if (in_first) begin
                        if (mHaveHdr) mFerr = 1;
                        mHaveHdr = 1;
                        mSum     = int'(ct_a);
                        mCount   = 0;
                    end else if (!mHaveHdr) begin
                        mFerr = 1;
                    end else begin
                        mSum = (mSum + int'(ct_a) * int'(sk)) % Q;
                        mCount++;
                        if (mCount == D) begin
                            mPending = decodeModel(mSum);
                            mHaveHdr = 0;
                            mPhase   = 1;
                        end
                    end
                end
            end else if (mPhase == 1) begin
                mLastResult = mPending;
                mPhase      = 2;
            end else if (out_ready) begin
                mPhase = 0;
            end
        end
    end

    // Single compare process: every output checked against the model each cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("inReady",  int'(in_ready),  int'(mPhase == 0));
            checkOutput("outValid", int'(out_valid), int'(mPhase == 2));
            checkOutput("result",   int'(result),    mLastResult);
            checkOutput("frameErr", int'(frame_err), int'(mFerr));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (randomReady) out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic applyStimulus(input bit first, input int a, input int s);
        int guard;
        in_valid = 1'b1;
        in_first = first;
        ct_a     = CW'(a);
        sk       = CW'(s);
        guard    = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) checkOutput("inReadyTimeout", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitOutValid();
        int guard;
        guard = 0;
        while (!out_valid && guard < 100) begin
            tick();
            guard++;
        end
        if (!out_valid) checkOutput("outValidTimeout", int'(out_valid), 1);
    endtask

    task automatic sendZeroFrame(input int b);
        applyStimulus(1'b1, b, 0);
        for (int i = 0; i < D; i++) applyStimulus(1'b0, 0, $urandom_range(0, Q - 1));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        ct_a      = '0;
        sk        = '0;
        out_ready = 1'b1;
        #2;
        checkOutput("rstOutValid", int'(out_valid), 0);
        checkOutput("rstResult",   int'(result),    0);
        checkOutput("rstFrameErr", int'(frame_err), 0);
        checkOutput("rstInReady",  int'(in_ready),  1);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        $display("[TB] b=336 with zero elements");
        sendZeroFrame(336);
        checkOutput("t1DecodeGap", int'(out_valid), 0);
        tick();
        checkOutput("t1OutValid", int'(out_valid), 1);
`ifdef LWE_DECRYPT_ROUND_EN
        checkOutput("t1Result", int'(result), 21);
`else
        checkOutput("t1Result", int'(result), 16);
`endif
        tick();

        $display("[TB] products of 1023*1023 wrap to 1");
        applyStimulus(1'b1, 0, 0);
        for (int i = 0; i < D; i++) applyStimulus(1'b0, 1023, 1023);
        waitOutValid();
`ifdef LWE_DECRYPT_ROUND_EN
        checkOutput("t2Result", int'(result), 0);
`else
        checkOutput("t2Result", int'(result), 4);
`endif
        tick();

        $display("[TB] rounding wrap near q");
        sendZeroFrame(1020);
        waitOutValid();
`ifdef LWE_DECRYPT_ROUND_EN
        checkOutput("t3Result", int'(result), 0);
`else
        checkOutput("t3Result", int'(result), 60);
`endif
        tick();

        $display("[TB] output backpressure");
        out_ready = 1'b0;
        sendZeroFrame(500);
        waitOutValid();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4HoldValid", int'(out_valid), 1);
            checkOutput("t4HoldReady", int'(in_ready),  0);
`ifdef LWE_DECRYPT_ROUND_EN
            checkOutput("t4HoldResult", int'(result), 31);
`else
            checkOutput("t4HoldResult", int'(result), 52);
`endif
        end
        out_ready = 1'b1;
        tick();
        checkOutput("t4ReleaseReady", int'(in_ready),  1);
        checkOutput("t4ReleaseValid", int'(out_valid), 0);

        $display("[TB] protocol violations");
        applyStimulus(1'b0, 5, 5);
        checkOutput("t5IdleErr",   int'(frame_err), 1);
        checkOutput("t5IdleReady", int'(in_ready),  1);
        tick();
        checkOutput("t5ErrPulse",  int'(frame_err), 0);
        applyStimulus(1'b1, 100, 0);
        applyStimulus(1'b0, 3, 7);
        applyStimulus(1'b0, 3, 7);
        applyStimulus(1'b1, 200, 0);
        checkOutput("t5RestartErr", int'(frame_err), 1);
        for (int i = 0; i < D; i++) applyStimulus(1'b0, 0, 9);
        waitOutValid();
`ifdef LWE_DECRYPT_ROUND_EN
        checkOutput("t5Result", int'(result), 13);
`else
        checkOutput("t5Result", int'(result), 8);
`endif
        tick();

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 77, 0);
        applyStimulus(1'b0, 11, 13);
        applyStimulus(1'b0, 17, 19);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6OutValid", int'(out_valid), 0);
        checkOutput("t6Result",   int'(result),    0);
        checkOutput("t6FrameErr", int'(frame_err), 0);
        checkOutput("t6InReady",  int'(in_ready),  1);
        tick();
        #2 rst_n = 1'b1;
        tick();
        sendZeroFrame(640);
        waitOutValid();
`ifdef LWE_DECRYPT_ROUND_EN
        checkOutput("t6Frame", int'(result), 40);
`else
        checkOutput("t6Frame", int'(result), 0);
`endif
        tick();

        $display("[TB] randomized frames");
        randomReady = 1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 7) == 0) applyStimulus(1'b0, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
            applyStimulus(1'b1, $urandom_range(0, Q - 1), 0);
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(1'b0, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
                applyStimulus(1'b1, $urandom_range(0, Q - 1), 0);
            end
            for (int i = 0; i < D; i++) begin
                applyStimulus(1'b0, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1));
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
        randomReady = 0;
        out_ready   = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
